vm_input_conditioner: RTL and testbench

//  Front-end stage that feeds the vending-machine controller. Synchronises,

---
 rtl/vm_pkg.sv | 28 ++
 rtl/vm_debounce_cell.sv | 62 ++++++
 rtl/vm_input_conditioner.sv | 105 ++++++++++
 tb/tb_vm_input_conditioner.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vm_pkg.sv
//------------------------------------------------------------------------------
// vm_pkg
// Constants shared by the vending-machine front end and its controller.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package vm_pkg;

  localparam int c_coin0_val = 1;
  localparam int c_coin1_val = 5;
  localparam int c_coin2_val = 10;
  localparam int c_coin3_val = 20;

  localparam int c_ch_l   = 0;
  localparam int c_ch_r   = 1;
  localparam int c_ch_c   = 2;
  localparam int c_ch_sw0 = 3;
  localparam int c_ch_sw1 = 4;
  localparam int c_ch_sw2 = 5;
  localparam int c_ch_sw3 = 6;
  localparam int c_num_ch = 7;

  typedef logic [4:0] coin_val_t;

endpackage

`default_nettype wire

// File: rtl/vm_debounce_cell.sv
//------------------------------------------------------------------------------
// vm_debounce_cell
// Two-flop synchroniser, stable-count debouncer and registered rising-edge flag.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module vm_debounce_cell #(
  parameter int DB_CNT = 250000,
  parameter int CNT_W  = 18
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DB_CNT - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_deb;
  logic             r_deb_q;
  logic             r_rise;
  logic [CNT_W-1:0] r_cnt;

  if (DB_CNT < 2 || (2 ** CNT_W) <= DB_CNT) begin : g_param_err
    $error("vm_debounce_cell: need DB_CNT >= 2 and 2**CNT_W > DB_CNT");
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_deb   <= 1'b0;
      r_deb_q <= 1'b0;
      r_rise  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
      r_deb_q <= r_deb;
      r_rise  <= r_deb & ~r_deb_q;
      // Any sample matching the accepted level restarts the stability count.
      if (r_sync2 == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == c_cnt_last) begin
        r_deb <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign level = r_deb;
  assign rise  = r_rise;

endmodule

`default_nettype wire

// File: rtl/vm_input_conditioner.sv
//------------------------------------------------------------------------------
// vm_input_conditioner
// Debounced one-cycle button pulses and single-event coin reporting.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module vm_input_conditioner
  import vm_pkg::*;
#(
  parameter int DB_CNT    = 250000,
  parameter int CNT_W     = 18,
  parameter int COIN0_VAL = c_coin0_val,
  parameter int COIN1_VAL = c_coin1_val,
  parameter int COIN2_VAL = c_coin2_val,
  parameter int COIN3_VAL = c_coin3_val
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       L_raw,
  input  logic       R_raw,
  input  logic       C_raw,
  input  logic [3:0] sw_raw,
  output logic       L_pulse,
  output logic       R_pulse,
  output logic       C_pulse,
  output logic       coin_valid,
  output logic [4:0] coin_value,
  output logic       coin_err
);

  localparam coin_val_t c_val0 = coin_val_t'(COIN0_VAL);
  localparam coin_val_t c_val1 = coin_val_t'(COIN1_VAL);
  localparam coin_val_t c_val2 = coin_val_t'(COIN2_VAL);
  localparam coin_val_t c_val3 = coin_val_t'(COIN3_VAL);

  if (COIN0_VAL < 0 || COIN0_VAL > 31 || COIN1_VAL < 0 || COIN1_VAL > 31 ||
      COIN2_VAL < 0 || COIN2_VAL > 31 || COIN3_VAL < 0 || COIN3_VAL > 31) begin : g_coin_val_err
    $error("vm_input_conditioner: coin values must fit in 5 bits");
  end

  logic [c_num_ch-1:0] w_raw;
  logic [c_num_ch-1:0] w_rise;
  logic [c_num_ch-1:0] w_level_unused;
  logic [3:0]          w_coin_rise;
  logic                w_coin_valid;
  logic                w_coin_err;
  coin_val_t           w_coin_value;

  assign w_raw[c_ch_l]              = L_raw;
  assign w_raw[c_ch_r]              = R_raw;
  assign w_raw[c_ch_c]              = C_raw;
  assign w_raw[c_ch_sw3:c_ch_sw0]   = sw_raw;

  for (genvar i = 0; i < c_num_ch; i++) begin : g_cell
    vm_debounce_cell #(
      .DB_CNT (DB_CNT),
      .CNT_W  (CNT_W)
    ) u_cell (
      .clk   (clk),
      .rst   (rst),
      .raw   (w_raw[i]),
      .level (w_level_unused[i]),
      .rise  (w_rise[i])
    );
  end

  assign w_coin_rise = w_rise[c_ch_sw3:c_ch_sw0];

  // Coins rising together cannot be told apart, so none of them is credited.
  always_comb begin
    w_coin_valid = 1'b0;
    w_coin_err   = 1'b0;
    w_coin_value = '0;
    case (w_coin_rise)
      4'b0000: ;
      4'b0001: begin w_coin_valid = 1'b1; w_coin_value = c_val0; end
      4'b0010: begin w_coin_valid = 1'b1; w_coin_value = c_val1; end
      4'b0100: begin w_coin_valid = 1'b1; w_coin_value = c_val2; end
      4'b1000: begin w_coin_valid = 1'b1; w_coin_value = c_val3; end
      default: w_coin_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      L_pulse    <= 1'b0;
      R_pulse    <= 1'b0;
      C_pulse    <= 1'b0;
      coin_valid <= 1'b0;
      coin_value <= '0;
      coin_err   <= 1'b0;
    end else begin
      L_pulse    <= w_rise[c_ch_l];
      R_pulse    <= w_rise[c_ch_r];
      C_pulse    <= w_rise[c_ch_c];
      coin_valid <= w_coin_valid;
      coin_value <= w_coin_value;
      coin_err   <= w_coin_err;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vm_input_conditioner.sv
//------------------------------------------------------------------------------
// tb_vm_input_conditioner
// Self-checking bench: window-based reference model, vector table, corner cases.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_vm_input_conditioner;

  localparam int DB  = 4;
  localparam int LAT = DB + 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       L_raw = 1'b1, R_raw = 1'b1, C_raw = 1'b1;
  logic [3:0] sw_raw = 4'hf;
  logic       L_pulse, R_pulse, C_pulse, coin_valid, coin_err;
  logic [4:0] coin_value;

  vm_input_conditioner #(.DB_CNT(DB), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .L_raw(L_raw), .R_raw(R_raw), .C_raw(C_raw),
    .sw_raw(sw_raw), .L_pulse(L_pulse), .R_pulse(R_pulse), .C_pulse(C_pulse),
    .coin_valid(coin_valid), .coin_value(coin_value), .coin_err(coin_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a channel's accepted level flips once the last DB
  // synchronised samples all disagree with it; pulses trail the flip.
  int coin_tbl[4] = '{1, 5, 10, 20};
  bit rwin[7][8];
  bit debh[7][4];
  int ecount = 0;
  int e_l = 0, e_r = 0, e_c = 0, e_v = 0, e_val = 0, e_e = 0;

  function automatic void model_step();
    bit rv[7];
    bit rise[7];
    bit flip, old;
    int n, val;
    rv = '{L_raw, R_raw, C_raw, sw_raw[0], sw_raw[1], sw_raw[2], sw_raw[3]};
    if (!rst) begin
      for (int ch = 0; ch < 7; ch++) begin
        for (int k = 0; k < 8; k++) rwin[ch][k] = 1'b0;
        for (int k = 0; k < 4; k++) debh[ch][k] = 1'b0;
      end
      e_l = 0; e_r = 0; e_c = 0; e_v = 0; e_val = 0; e_e = 0;
      return;
    end
    for (int ch = 0; ch < 7; ch++) begin
      for (int k = 7; k > 0; k--) rwin[ch][k] = rwin[ch][k-1];
      rwin[ch][0] = rv[ch];
      old  = debh[ch][0];
      flip = 1'b1;
      for (int k = 2; k <= DB + 1; k++) if (rwin[ch][k] == old) flip = 1'b0;
      for (int k = 3; k > 0; k--) debh[ch][k] = debh[ch][k-1];
      debh[ch][0] = flip ? ~old : old;
      rise[ch] = debh[ch][2] & ~debh[ch][3];
    end
    n = 0; val = 0;
    for (int i = 0; i < 4; i++) if (rise[3+i]) begin n++; val += coin_tbl[i]; end
    e_l = int'(rise[0]); e_r = int'(rise[1]); e_c = int'(rise[2]);
    e_v = (n == 1) ? 1 : 0;
    e_val = (n == 1) ? val : 0;
    e_e = (n >= 2) ? 1 : 0;
  endfunction

  initial forever begin
    @(posedge clk);
    ecount++;
    model_step();
  end

  // Model comparison plus pulse bookkeeping for the directed checks.
  bit chk_en = 1'b0;
  int cnt[5];
  int first[5];
  int vsum, first_val;

  task automatic clr_mon();
    for (int i = 0; i < 5; i++) begin cnt[i] = 0; first[i] = -1; end
    vsum = 0; first_val = -1;
  endtask

  initial begin
    clr_mon();
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("model L_pulse", int'(L_pulse), e_l);
        chk("model R_pulse", int'(R_pulse), e_r);
        chk("model C_pulse", int'(C_pulse), e_c);
        chk("model coin_valid", int'(coin_valid), e_v);
        chk("model coin_value", int'(coin_value), e_val);
        chk("model coin_err", int'(coin_err), e_e);
      end
      if (L_pulse)    begin cnt[0]++; if (first[0] < 0) first[0] = ecount; end
      if (R_pulse)    begin cnt[1]++; if (first[1] < 0) first[1] = ecount; end
      if (C_pulse)    begin cnt[2]++; if (first[2] < 0) first[2] = ecount; end
      if (coin_valid) begin
        cnt[3]++; vsum += int'(coin_value);
        if (first[3] < 0) begin first[3] = ecount; first_val = int'(coin_value); end
      end
      if (coin_err)   begin cnt[4]++; if (first[4] < 0) first[4] = ecount; end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic l, input logic r, input logic c, input logic [3:0] sw);
    L_raw = l; R_raw = r; C_raw = c; sw_raw = sw;
  endtask

  typedef struct {
    logic       l, r, c;
    logic [3:0] sw;
    int         nl, nr, nc, nv, ne, vs;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int e0, lat;

    tbl[0] = '{1'b1, 1'b0, 1'b0, 4'b0000, 1, 0, 0, 0, 0, 0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 4'b0000, 0, 1, 0, 0, 0, 0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 4'b0000, 1, 1, 0, 0, 0, 0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 4'b0100, 0, 0, 0, 1, 0, 10};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 4'b1000, 0, 0, 0, 1, 0, 20};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 4'b0011, 0, 0, 0, 0, 1, 0};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 4'b0001, 0, 0, 1, 1, 0, 1};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 4'b0010, 0, 0, 0, 1, 0, 5};
    tbl[8] = '{1'b1, 1'b0, 1'b0, 4'b1111, 1, 0, 0, 0, 1, 0};

    // Reset held with every input high, then released.
    @(negedge clk);
    chk_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset outputs", int'({L_pulse, R_pulse, C_pulse, coin_valid, coin_err, coin_value}), 0);
    end
    rst = 1'b1;
    clr_mon();
    e0 = ecount;
    cyc(20);
    chk("reset-release L count", cnt[0], 1);
    chk("reset-release R count", cnt[1], 1);
    chk("reset-release C count", cnt[2], 1);
    chk("reset-release coin_err count", cnt[4], 1);
    chk("reset-release coin_valid count", cnt[3], 0);
    chk("reset-release L latency", first[0] - (e0 + 1), LAT);
    chk("reset-release err latency", first[4] - (e0 + 1), LAT);
    drive(1'b0, 1'b0, 1'b0, 4'b0000);
    cyc(14);

    // Vector table: step, hold, release.
    for (int v = 0; v < 9; v++) begin
      drive(tbl[v].l, tbl[v].r, tbl[v].c, tbl[v].sw);
      clr_mon();
      e0 = ecount;
      cyc(20);
      drive(1'b0, 1'b0, 1'b0, 4'b0000);
      cyc(14);
      chk($sformatf("vec%0d L count", v), cnt[0], tbl[v].nl);
      chk($sformatf("vec%0d R count", v), cnt[1], tbl[v].nr);
      chk($sformatf("vec%0d C count", v), cnt[2], tbl[v].nc);
      chk($sformatf("vec%0d valid count", v), cnt[3], tbl[v].nv);
      chk($sformatf("vec%0d err count", v), cnt[4], tbl[v].ne);
      chk($sformatf("vec%0d value sum", v), vsum, tbl[v].vs);
      lat = 1000;
      for (int i = 0; i < 5; i++) if (first[i] >= 0 && first[i] - (e0 + 1) < lat) lat = first[i] - (e0 + 1);
      chk($sformatf("vec%0d latency", v), lat, LAT);
    end

    // Bounce on C, then steady high.
    clr_mon();
    drive(1'b0, 1'b0, 1'b1, 4'b0000); cyc(1);
    C_raw = 1'b0; cyc(1);
    C_raw = 1'b1; cyc(2);
    C_raw = 1'b0; cyc(1);
    C_raw = 1'b1;
    e0 = ecount;
    cyc(20);
    chk("bounce C count", cnt[2], 1);
    chk("bounce C latency", first[2] - (e0 + 1), LAT);
    C_raw = 1'b0;
    cyc(14);

    // Glitch shorter than the debounce window.
    clr_mon();
    C_raw = 1'b1; cyc(3);
    C_raw = 1'b0; cyc(14);
    chk("glitch C count", cnt[2], 0);

    // Staggered coins are credited separately.
    clr_mon();
    sw_raw = 4'b0001; e0 = ecount; cyc(2);
    sw_raw = 4'b0011; cyc(20);
    sw_raw = 4'b0000; cyc(14);
    chk("stagger valid count", cnt[3], 2);
    chk("stagger err count", cnt[4], 0);
    chk("stagger first value", first_val, 1);
    chk("stagger value sum", vsum, 6);
    chk("stagger first latency", first[3] - (e0 + 1), LAT);

    // Reset in the middle of an R count.
    clr_mon();
    R_raw = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(1);
    chk("mid-reset R before reset", cnt[1], 0);
    rst = 1'b1;
    clr_mon();
    e0 = ecount;
    cyc(20);
    chk("mid-reset R count", cnt[1], 1);
    chk("mid-reset R latency", first[1] - (e0 + 1), LAT);
    R_raw = 1'b0;
    cyc(14);

    // Random activity against the reference model.
    for (int t = 0; t < 1500; t++) begin
      if ($urandom_range(0, 5) == 0) L_raw = ~L_raw;
      if ($urandom_range(0, 5) == 0) R_raw = ~R_raw;
      if ($urandom_range(0, 5) == 0) C_raw = ~C_raw;
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 7) == 0) sw_raw[i] = ~sw_raw[i];
      cyc(1);
    end
    drive(1'b0, 1'b0, 1'b0, 4'b0000);
    cyc(14);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
